// File: rtl/mips_mem_pkg.sv
// ---------------------------------------------------------------------------
// mips_mem_pkg
// Shared definitions for the MIPS data-memory controller slice:
//   - FSM state encoding of dmem_ctrl (IDLE / WAIT / RESP)
//   - word width and byte-lane count
//   - default MMIO output-register address
//   - latched-request record and the byte-lane merge helper
// ---------------------------------------------------------------------------
package mips_mem_pkg;

    localparam int WORD_W = 32;
    localparam int LANES  = 4;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_FF00;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Source of the load data presented while a response is outstanding.
    typedef enum logic [1:0] {
        SRC_ZERO  = 2'd0,
        SRC_ARRAY = 2'd1,
        SRC_MMIO  = 2'd2
    } rd_src_e;

    // Request captured at acceptance; only the word index of the address matters.
    typedef struct packed {
        logic        write;
        logic [29:0] widx;
        logic [31:0] wdata;
        logic [3:0]  be;
    } mem_req_t;

    // Replace the byte lanes of old_w selected by be with the lanes of new_w.
    function automatic logic [WORD_W-1:0] lane_merge(
        input logic [WORD_W-1:0] old_w,
        input logic [WORD_W-1:0] new_w,
        input logic [LANES-1:0]  be
    );
        logic [WORD_W-1:0] res;
        res = old_w;
        for (int i = 0; i < LANES; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// DEPTH x 32-bit data array with byte-lane synchronous write and a registered
// read. Contents are never cleared; the read register only changes when re is
// high, so it holds the last loaded word between loads.
// Ports:
//   clk    in  1      rising-edge clock
//   we     in  1      write strobe
//   re     in  1      read strobe (captures mem[addr] into rdata)
//   addr   in  AW     word index
//   be     in  4      byte-lane enables for the write
//   wdata  in  32     write data
//   rdata  out 32     registered read data
// ---------------------------------------------------------------------------
module dmem_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [LANES-1:0]         be,
    input  logic [WORD_W-1:0]        wdata,
    output logic [WORD_W-1:0]        rdata
);

    logic [WORD_W-1:0] mem_r [DEPTH];
    logic [WORD_W-1:0] rdata_r;

    // Byte-lane write port.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (we && be[i]) begin
                mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/dmem_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_ctrl
// Data-memory controller for the pipelined MIPS core memory stage.
// One request at a time: accepted in IDLE, optional WAIT_STATES cycles in
// WAIT, one-cycle response in RESP. Stores and loads commit on the edge that
// enters RESP; with WAIT_STATES = 0 that is the acceptance edge itself, so the
// commit operands come straight from the request inputs in that case.
//
// Optional feature (macro DMEM_MMIO_EN): a byte-lane writable / readable
// output register at MMIO_BASE. Without the macro MMIO_BASE is an ordinary
// out-of-range address and mmio_out is constant 0.
//
// Ports:
//   clk        in  1   rising-edge clock
//   reset      in  1   synchronous active-high reset
//   req_valid  in  1   request present
//   req_write  in  1   1 = store, 0 = load
//   req_addr   in  32  byte address, bits [1:0] ignored
//   req_wdata  in  32  store data
//   req_be     in  4   store byte enables
//   req_ready  out 1   controller idle, request accepted this cycle if valid
//   rsp_valid  out 1   one-cycle response pulse
//   rsp_rdata  out 32  load data (0 for stores and errors)
//   rsp_err    out 1   out-of-range access, qualified by rsp_valid
//   mmio_out   out 32  MMIO output register
// ---------------------------------------------------------------------------
module dmem_ctrl
    import mips_mem_pkg::*;
#(
    parameter int          DEPTH       = 64,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [LANES-1:0]  req_be,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [WORD_W-1:0] mmio_out
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    logic [1:0]        state_r;
    logic [2:0]        cnt_r;
    mem_req_t          req_r;
    logic              rsp_valid_r;
    logic              rsp_err_r;
    rd_src_e           rd_src_r;
    logic [WORD_W-1:0] arr_rdata_s;
    logic [WORD_W-1:0] mmio_val_s;

    mem_req_t          cur_s;
    logic              commit_s;
    logic              in_range_s;
    logic              mmio_hit_s;
    logic              arr_we_s;
    logic              arr_re_s;
    logic              unused_addr_s;

    // Byte offset bits have no meaning for a word-wide memory.
    assign unused_addr_s = ^req_addr[1:0];

    assign req_ready = (state_r == ST_IDLE);

    // Commit strobe and the request it operates on.
    always_comb begin
        commit_s = 1'b0;
        cur_s    = req_r;
        if (WAIT_STATES == 0) begin
            commit_s = (state_r == ST_IDLE) && req_valid;
            cur_s    = '{write: req_write, widx: req_addr[31:2], wdata: req_wdata, be: req_be};
        end else begin
            commit_s = (state_r == ST_WAIT) && (cnt_r == 3'd0);
            cur_s    = req_r;
        end
    end

    // Address decode on the committing request.
    always_comb begin
        in_range_s = ({2'b00, cur_s.widx} < 32'(DEPTH));
`ifdef DMEM_MMIO_EN
        mmio_hit_s = !in_range_s && (cur_s.widx == MMIO_BASE[31:2]);
`else
        mmio_hit_s = 1'b0;
`endif
    end

    assign arr_we_s = commit_s && cur_s.write && in_range_s;
    assign arr_re_s = commit_s && !cur_s.write && in_range_s;

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we_s),
        .re    (arr_re_s),
        .addr  (cur_s.widx[AW-1:0]),
        .be    (cur_s.be),
        .wdata (cur_s.wdata),
        .rdata (arr_rdata_s)
    );

    // Request FSM, wait counter and request latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
            req_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_r <= '{write: req_write, widx: req_addr[31:2],
                                   wdata: req_wdata, be: req_be};
                        if (WAIT_STATES == 0) begin
                            state_r <= ST_RESP;
                        end else begin
                            state_r <= ST_WAIT;
                            cnt_r   <= WS_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 3'd0) begin
                        state_r <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Response flags captured at the commit edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rd_src_r    <= SRC_ZERO;
        end else begin
            rsp_valid_r <= commit_s;
            if (commit_s) begin
                rsp_err_r <= !(in_range_s || mmio_hit_s);
                if (cur_s.write || !(in_range_s || mmio_hit_s)) begin
                    rd_src_r <= SRC_ZERO;
                end else if (in_range_s) begin
                    rd_src_r <= SRC_ARRAY;
                end else begin
                    rd_src_r <= SRC_MMIO;
                end
            end
        end
    end

`ifdef DMEM_MMIO_EN
    logic [WORD_W-1:0] mmio_r;

    // MMIO output register, byte-lane writable at the commit edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            mmio_r <= '0;
        end else if (commit_s && cur_s.write && mmio_hit_s) begin
            mmio_r <= lane_merge(mmio_r, cur_s.wdata, cur_s.be);
        end
    end

    assign mmio_val_s = mmio_r;
`else
    assign mmio_val_s = 32'h0000_0000;
`endif

    // Load data comes from whichever register the committed access selected;
    // the array read register and mmio value only change at a later commit.
    always_comb begin
        case (rd_src_r)
            SRC_ARRAY: rsp_rdata = arr_rdata_s;
            SRC_MMIO:  rsp_rdata = mmio_val_s;
            SRC_ZERO:  rsp_rdata = 32'h0000_0000;
            default:   rsp_rdata = 32'h0000_0000;
        endcase
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;
    assign mmio_out  = mmio_val_s;

endmodule
